next_mon_host: RTL

Host-side end of the NeXT monitor serial link: serializes 40-bit command packets onto `to_mon` and deserializes 40-bit reply packets from `from_mon`, both clocked by `mon_clk`. Acts as the computer side of the soundbox link. Used as a bench driver for the soundbox and as the front end of a host bridge. All logic lives in the `mon_clk` domain. No CDC inside.

---
 rtl/next_mon_pkg.sv | 40 ++++
 rtl/mon_tx_fifo.sv | 77 +++++++
 rtl/next_mon_host.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/next_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : next_mon_pkg
// Description : Shared types and constants for the NeXT monitor serial link.
//               Holds the packet width, the frame-bit counter width, the TX/RX
//               state encodings and the well-known packet header values.
// Revision    : 1.0 - initial release
// ============================================================================
package next_mon_pkg;

  // Packet width on the monitor link (start + 40 data + stop per frame).
  localparam int unsigned MON_PKT_W = 40;

  // Frame-bit counter: counts 39..0, so 6 bits.
  localparam int unsigned MON_CNT_W = 6;

  // Gap counter width: GAP_CYCLES is limited to 1..15.
  localparam int unsigned MON_GAP_W = 4;

  // Header values (bits [39:16]) of commonly issued host commands.
  localparam logic [23:0] MON_HDR_POWER_ON = 24'hC0_0000;
  localparam logic [23:0] MON_HDR_KBD_POLL = 24'h02_0000;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_STOP  = 3'd3,
    TX_GAP   = 3'd4
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_HUNT      = 2'd0,
    RX_DATA      = 2'd1,
    RX_STOP      = 2'd2,
    RX_WAIT_HIGH = 2'd3
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/mon_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mon_tx_fifo
// Description : Small synchronous FIFO queuing host command packets in front
//               of the TX serializer. Show-ahead: rd_data is the head entry
//               whenever empty is low.
// Ports       : clk      - clock
//               rst_n    - synchronous active-low reset (empties the FIFO)
//               push     - write wr_data (ignored when full)
//               wr_data  - entry to write
//               pop      - drop the head entry (ignored when empty)
//               rd_data  - head entry
//               full     - no free entries
//               empty    - no valid entries
//               count    - number of valid entries
// Revision    : 1.0 - initial release
// ============================================================================
module mon_tx_fifo #(
  parameter int unsigned DEPTH = 4,   // power of two, >= 2
  parameter int unsigned WIDTH = 40
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule
`default_nettype wire

// File: rtl/next_mon_host.sv
`default_nettype none
// ============================================================================
// Module      : next_mon_host
// Description : Host end of the NeXT monitor serial link. Serializes 40-bit
//               command packets onto to_mon and deserializes 40-bit replies
//               from from_mon. Frame: start(0), 40 data bits MSB first,
//               stop(1). Everything runs on mon_clk.
// Build macro : MON_HOST_TX_FIFO_EN - adds a FIFO_DEPTH-entry TX queue in
//               front of the serializer (tx_ready = !full).
// Ports       : mon_clk    - link clock, one bit per cycle
//               hw_reset_n - synchronous active-low reset
//               tx_data    - packet to send ([39:16] header, [15:0] payload)
//               tx_valid   - tx_data presented
//               tx_ready   - packet accepted when tx_valid & tx_ready
//               to_mon     - serial line to the soundbox, idles high
//               from_mon   - serial line from the soundbox, idles high
//               rx_data    - last good received packet
//               rx_valid   - one-cycle pulse when rx_data updates
//               rx_err     - one-cycle pulse on a bad stop bit
//               tx_busy    - frame in progress or packet queued
// Revision    : 1.0 - initial release
// ============================================================================
module next_mon_host
  import next_mon_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 4,  // 1..15
  parameter int unsigned FIFO_DEPTH = 4   // power of two
) (
  input  logic                 mon_clk,
  input  logic                 hw_reset_n,
  input  logic [MON_PKT_W-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 to_mon,
  input  logic                 from_mon,
  output logic [MON_PKT_W-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_err,
  output logic                 tx_busy
);

  // ---------------------------------------------------------------- TX source
  logic                 src_valid;
  logic [MON_PKT_W-1:0] src_data;
  tx_state_e            tx_state_q, tx_state_d;

`ifdef MON_HOST_TX_FIFO_EN
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        tx_take;

  assign tx_take = (tx_state_q == TX_IDLE) && src_valid;

  mon_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (MON_PKT_W)
  ) u_tx_fifo (
    .clk     (mon_clk),
    .rst_n   (hw_reset_n),
    .push    (tx_valid && tx_ready),
    .wr_data (tx_data),
    .pop     (tx_take),
    .rd_data (src_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign src_valid = !fifo_empty;
  assign tx_ready  = hw_reset_n && !fifo_full;
  assign tx_busy   = (tx_state_q != TX_IDLE) || (fifo_count != '0);
`else
  // Direct handshake: the port feeds the serializer, accepted only in IDLE.
  // FIFO_DEPTH has no meaning here; the condition holds for every legal value.
  if (FIFO_DEPTH != 0) begin : g_direct_src
    assign src_valid = tx_valid;
    assign src_data  = tx_data;
    assign tx_ready  = hw_reset_n && (tx_state_q == TX_IDLE);
    assign tx_busy   = (tx_state_q != TX_IDLE);
  end
`endif

  // ---------------------------------------------------------------- TX FSM
  // to_mon is registered: each state computes the line value for the
  // following cycle, so acceptance at N puts the start bit on the line at N+1.
  logic [MON_PKT_W-1:0] tx_shift_q, tx_shift_d;
  logic [MON_CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [MON_GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic                 to_mon_q, to_mon_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    to_mon_d   = 1'b1;
    case (tx_state_q)
      TX_IDLE: begin
        if (src_valid) begin
          tx_shift_d = src_data;
          tx_state_d = TX_START;
          to_mon_d   = 1'b0;
        end
      end
      TX_START: begin
        to_mon_d   = tx_shift_q[MON_PKT_W-1];
        tx_shift_d = {tx_shift_q[MON_PKT_W-2:0], 1'b0};
        tx_cnt_d   = MON_CNT_W'(MON_PKT_W - 1);
        tx_state_d = TX_DATA;
      end
      TX_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = TX_STOP;          // line shows the stop bit next
        end else begin
          to_mon_d   = tx_shift_q[MON_PKT_W-1];
          tx_shift_d = {tx_shift_q[MON_PKT_W-2:0], 1'b0};
          tx_cnt_d   = tx_cnt_q - MON_CNT_W'(1);
        end
      end
      TX_STOP: begin
        gap_cnt_d  = MON_GAP_W'(GAP_CYCLES - 1);
        tx_state_d = TX_GAP;
      end
      TX_GAP: begin
        if (gap_cnt_q == '0) begin
          tx_state_d = TX_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - MON_GAP_W'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- RX FSM
  rx_state_e            rx_state_q, rx_state_d;
  logic                 rx_s_q;
  logic [MON_PKT_W-1:0] rx_shift_q, rx_shift_d;
  logic [MON_CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [MON_PKT_W-1:0] rx_data_q, rx_data_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_shift_d = rx_shift_q;
    rx_cnt_d   = rx_cnt_q;
    rx_data_d  = rx_data_q;
    case (rx_state_q)
      RX_HUNT: begin
        if (!rx_s_q) begin
          rx_cnt_d   = MON_CNT_W'(MON_PKT_W - 1);
          rx_state_d = RX_DATA;
        end
      end
      RX_DATA: begin
        rx_shift_d = {rx_shift_q[MON_PKT_W-2:0], rx_s_q};
        if (rx_cnt_q == '0) begin
          rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q - MON_CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_s_q) begin
          rx_data_d  = rx_shift_q;
          rx_state_d = RX_HUNT;
        end else begin
          rx_state_d = RX_WAIT_HIGH;   // a stuck-low line must not look like a start bit
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_s_q) begin
          rx_state_d = RX_HUNT;
        end
      end
      default: rx_state_d = RX_HUNT;
    endcase
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge mon_clk) begin
    if (!hw_reset_n) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= '0;
      tx_cnt_q   <= '0;
      gap_cnt_q  <= '0;
      to_mon_q   <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_state_q <= RX_HUNT;
      rx_shift_q <= '0;
      rx_cnt_q   <= '0;
      rx_data_q  <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      to_mon_q   <= to_mon_d;
      rx_s_q     <= from_mon;
      rx_state_q <= rx_state_d;
      rx_shift_q <= rx_shift_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_data_q  <= rx_data_d;
    end
  end

  // The stop bit is judged in the same cycle it is seen on rx_s, so the
  // pulses and the new rx_data appear 42 cycles after the start bit.
  assign to_mon   = to_mon_q;
  assign rx_valid = hw_reset_n && (rx_state_q == RX_STOP) && rx_s_q;
  assign rx_err   = hw_reset_n && (rx_state_q == RX_STOP) && !rx_s_q;
  assign rx_data  = rx_valid ? rx_shift_q : rx_data_q;

endmodule
`default_nettype wire
